// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle controller.
// Holds the FSM state enum, the instruction-class enum, the RV32I major
// opcodes recognised by the decoder, the operand-B (imme_sel) codes, the
// writeback-source codes and the ALU codes the controller emits directly.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_NONE
  } iclass_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_RS2 = 3'b000;
  localparam logic [2:0] IMM_I   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_S   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_UJ  = 3'b101;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decoder.
// Ports:
//   ir        in   32  instruction register contents
//   iclass    out       instruction class (CLS_NONE when unsupported)
//   imme_sel  out  3    operand-B select for this instruction
//   alu_ctrl  out  4    ALU operation code for this instruction
//   legal     out  1    opcode is one the controller supports
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_e     iclass,
  output logic [2:0]  imme_sel,
  output logic [3:0]  alu_ctrl,
  output logic        legal
);

  // Register specifiers and the upper immediate bits never influence control.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

  always_comb begin
    iclass   = CLS_NONE;
    imme_sel = IMM_RS2;
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (ir[6:0])
      OP_R: begin
        iclass   = CLS_R;
        alu_ctrl = {ir[30], ir[14:12]};
      end
      OP_IMM: begin
        iclass   = CLS_IALU;
        imme_sel = IMM_I;
        // ir[30] is an opcode modifier only for shift-right immediates;
        // for every other funct3 it is just an immediate bit.
        alu_ctrl = {(ir[14:12] == 3'b101) & ir[30], ir[14:12]};
      end
      OP_LOAD: begin
        iclass   = CLS_LOAD;
        imme_sel = IMM_I;
      end
      OP_JALR: begin
        iclass   = CLS_JALR;
        imme_sel = IMM_I;
      end
      OP_STORE: begin
        iclass   = CLS_STORE;
        imme_sel = IMM_S;
      end
      OP_BRANCH: begin
        iclass   = CLS_BRANCH;
        imme_sel = IMM_B;
      end
      OP_LUI: begin
        iclass   = CLS_LUI;
        imme_sel = IMM_U;
        alu_ctrl = ALU_PASS_B;
      end
      OP_AUIPC: begin
        iclass   = CLS_AUIPC;
        imme_sel = IMM_U;
      end
      OP_JAL: begin
        iclass   = CLS_JAL;
        imme_sel = IMM_UJ;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32I datapath.
// Sequence: BOOT -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with
// unsupported opcodes parking in TRAP until reset.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   instr, instr_valid   fetched word and its acknowledge (used only in FETCH)
//   mem_ack              data access complete (used only in MEM)
//   br_taken             branch comparator result (used only in EXEC)
//   fetch_req            instruction request
//   op_a_sel, imme_sel   operand selects; alu_ctrl ALU operation
//   mem_req, mem_we      data-memory request / write enable
//   reg_we, wb_sel       register write enable / writeback source
//   pc_we, pc_sel        PC update strobe / PC source
//   illegal              sticky unsupported-opcode flag
// Handshakes: fetch_req and mem_req are request levels that stay high until
// the matching acknowledge (instr_valid / mem_ack) is seen high on a rising
// edge; the transfer completes on that edge. Acknowledges outside the state
// that issued the request are ignored.
// All outputs come from state_q and ir_q only. The exceptions are pc_sel in
// EXEC (follows br_taken) and pc_we on a store's mem_ack, which must act in
// the same cycle their qualifying input arrives.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        mem_ack,
  input  logic        br_taken,
  output logic        fetch_req,
  output logic        op_a_sel,
  output logic [2:0]  imme_sel,
  output logic [3:0]  alu_ctrl,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  iclass_e     iclass;
  logic [2:0]  dec_imme_sel;
  logic [3:0]  dec_alu_ctrl;
  logic        dec_legal;

  ctrl_decode u_decode (
    .ir       (ir_q),
    .iclass   (iclass),
    .imme_sel (dec_imme_sel),
    .alu_ctrl (dec_alu_ctrl),
    .legal    (dec_legal)
  );

  logic is_store, is_load, is_jump, opa_pc, ops_active;
  assign is_store   = (iclass == CLS_STORE);
  assign is_load    = (iclass == CLS_LOAD);
  assign is_jump    = (iclass == CLS_JAL) || (iclass == CLS_JALR);
  assign opa_pc     = (iclass == CLS_AUIPC) || (iclass == CLS_JAL) ||
                      (iclass == CLS_BRANCH);
  assign ops_active = (state_q == ST_EXEC) || (state_q == ST_MEM) ||
                      (state_q == ST_WB);

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (is_load || is_store)         state_d = ST_MEM;
        else if (iclass == CLS_BRANCH)   state_d = ST_FETCH;
        else                             state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ack) state_d = is_store ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_BOOT;
      ir_q      <= NOP_INSTR;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode.
  always_comb begin
    fetch_req = 1'b0;
    op_a_sel  = ops_active & opa_pc;
    imme_sel  = ops_active ? dec_imme_sel : IMM_RS2;
    alu_ctrl  = ops_active ? dec_alu_ctrl : ALU_ADD;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    case (state_q)
      ST_FETCH: fetch_req = 1'b1;
      ST_EXEC: begin
        if (iclass == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = br_taken;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        // A store has no writeback, so the PC advances on its acknowledge.
        pc_we   = is_store & mem_ack;
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        pc_sel = is_jump;
        if (is_load)      wb_sel = WB_MEM;
        else if (is_jump) wb_sel = WB_PC4;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Inputs change after a rising edge;
// outputs are sampled on the falling edge. Output vectors are packed as
// {fetch_req, op_a_sel, imme_sel, alu_ctrl, mem_req, mem_we, reg_we,
//  wb_sel, pc_we, pc_sel, illegal}.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid, mem_ack, br_taken;
  logic        fetch_req, op_a_sel, mem_req, mem_we, reg_we, pc_we, pc_sel, illegal;
  logic [2:0]  imme_sel;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wb_sel;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .mem_ack(mem_ack), .br_taken(br_taken), .fetch_req(fetch_req),
    .op_a_sel(op_a_sel), .imme_sel(imme_sel), .alu_ctrl(alu_ctrl),
    .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel),
    .pc_we(pc_we), .pc_sel(pc_sel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {fetch_req, op_a_sel, imme_sel, alu_ctrl, mem_req, mem_we,
                reg_we, wb_sel, pc_we, pc_sel, illegal};

  function automatic logic [16:0] ov(input logic f, input logic a,
      input logic [2:0] im, input logic [3:0] alu, input logic mr,
      input logic mw, input logic rw, input logic [1:0] wb, input logic pw,
      input logic ps, input logic il);
    return {f, a, im, alu, mr, mw, rw, wb, pw, ps, il};
  endfunction

  localparam logic [16:0] ZERO_V  = 17'd0;
  localparam logic [16:0] FETCH_V = 17'h10000;

  // Instructions that go EXEC -> WB, with their expected controls.
  logic [31:0] t_instr [8] = '{32'h002081B3, 32'h402081B3, 32'h40315093,
                               32'hC0000093, 32'h123450B7, 32'h00001097,
                               32'h008000EF, 32'h000080E7};
  logic [2:0]  t_imme  [8] = '{3'b000, 3'b000, 3'b001, 3'b001,
                               3'b100, 3'b100, 3'b101, 3'b001};
  logic        t_opa   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0]  t_alu   [8] = '{4'b0000, 4'b1000, 4'b1101, 4'b0000,
                               4'b1111, 4'b0000, 4'b0000, 4'b0000};
  logic [1:0]  t_wb    [8] = '{2'b00, 2'b00, 2'b00, 2'b00,
                               2'b00, 2'b00, 2'b10, 2'b10};
  logic        t_ps    [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  // Waits (bounded) for FETCH, presents w for one cycle; returns just after
  // the accepting edge, i.e. at the start of DECODE.
  task automatic issue(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    while (fetch_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fetch_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait: fetch_req=%b want 1", fetch_req);
    end
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; instr = '0; instr_valid = 1'b0; mem_ack = 1'b0; br_taken = 1'b0;
    #12;
    checks++;
    if (obs !== ZERO_V) begin errors++; $display("FAIL reset_hold: got %b want %b", obs, ZERO_V); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== ZERO_V) begin errors++; $display("FAIL boot: got %b want %b", obs, ZERO_V); end
    @(negedge clk);
    checks++;
    if (obs !== FETCH_V) begin errors++; $display("FAIL boot_to_fetch: got %b want %b", obs, FETCH_V); end
  endtask

  task automatic test_wb_class;
    logic [16:0] e_exec, e_wb;
    for (int i = 0; i < 8; i++) begin
      e_exec = ov(0, t_opa[i], t_imme[i], t_alu[i], 0, 0, 0, 2'b00, 0, 0, 0);
      e_wb   = ov(0, t_opa[i], t_imme[i], t_alu[i], 0, 0, 1, t_wb[i], 1, t_ps[i], 0);
      issue(t_instr[i]);
      @(negedge clk);
      checks++;
      if (obs !== ZERO_V) begin errors++; $display("FAIL decode[%0d]: got %b want %b", i, obs, ZERO_V); end
      @(negedge clk);
      checks++;
      if (obs !== e_exec) begin errors++; $display("FAIL exec[%0d]: got %b want %b", i, obs, e_exec); end
      @(negedge clk);
      checks++;
      if (obs !== e_wb) begin errors++; $display("FAIL wb[%0d]: got %b want %b", i, obs, e_wb); end
      // Fourth cycle after the accepting FETCH cycle is FETCH again.
      @(negedge clk);
      checks++;
      if (obs !== FETCH_V) begin errors++; $display("FAIL refetch[%0d]: got %b want %b", i, obs, FETCH_V); end
    end
  endtask

  task automatic test_load;
    logic [16:0] e_mem, e_wb;
    e_mem = ov(0, 0, 3'b001, 4'b0000, 1, 0, 0, 2'b00, 0, 0, 0);
    e_wb  = ov(0, 0, 3'b001, 4'b0000, 0, 0, 1, 2'b01, 1, 0, 0);
    issue(32'h0000A183);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== ov(0, 0, 3'b001, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 0)) begin
      errors++; $display("FAIL lw_exec: got %b", obs);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      mem_ack = (k == 3);
      @(negedge clk);
      checks++;
      if (obs !== e_mem) begin errors++; $display("FAIL lw_mem[%0d]: got %b want %b", k, obs, e_mem); end
    end
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== e_wb) begin errors++; $display("FAIL lw_wb: got %b want %b", obs, e_wb); end
    @(negedge clk);
    checks++;
    if (obs !== FETCH_V) begin errors++; $display("FAIL lw_refetch: got %b want %b", obs, FETCH_V); end
  endtask

  task automatic test_store;
    logic [16:0] e_wait, e_ack;
    e_wait = ov(0, 0, 3'b011, 4'b0000, 1, 1, 0, 2'b00, 0, 0, 0);
    e_ack  = ov(0, 0, 3'b011, 4'b0000, 1, 1, 0, 2'b00, 1, 0, 0);
    issue(32'h0020A023);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      mem_ack = (k == 2);
      @(negedge clk);
      checks++;
      if (obs !== (k == 2 ? e_ack : e_wait)) begin
        errors++; $display("FAIL sw_mem[%0d]: got %b want %b", k, obs, (k == 2 ? e_ack : e_wait));
      end
    end
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== FETCH_V) begin errors++; $display("FAIL sw_refetch: got %b want %b", obs, FETCH_V); end
  endtask

  task automatic test_branch;
    logic [16:0] e_exec;
    for (int t = 1; t >= 0; t--) begin
      br_taken = t[0];
      e_exec = ov(0, 1, 3'b010, 4'b0000, 0, 0, 0, 2'b00, 1, t[0], 0);
      issue(32'h00208463);
      @(negedge clk);
      checks++;
      if (obs !== ZERO_V) begin errors++; $display("FAIL beq_decode[%0d]: got %b want %b", t, obs, ZERO_V); end
      @(negedge clk);
      checks++;
      if (obs !== e_exec) begin errors++; $display("FAIL beq_exec[%0d]: got %b want %b", t, obs, e_exec); end
      @(negedge clk);
      checks++;
      if (obs !== FETCH_V) begin errors++; $display("FAIL beq_refetch[%0d]: got %b want %b", t, obs, FETCH_V); end
    end
    br_taken = 1'b0;
  endtask

  task automatic test_stray_acks;
    mem_ack = 1'b1; br_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== FETCH_V) begin errors++; $display("FAIL stray_ack[%0d]: got %b want %b", k, obs, FETCH_V); end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; br_taken = 1'b0;
  endtask

  task automatic test_trap;
    logic [16:0] e_trap;
    e_trap = ov(0, 0, 3'b000, 4'b0000, 0, 0, 0, 2'b00, 0, 0, 1);
    issue(32'h0000007F);
    @(negedge clk);
    checks++;
    if (obs !== ZERO_V) begin errors++; $display("FAIL trap_decode: got %b want %b", obs, ZERO_V); end
    instr = 32'h002081B3; instr_valid = 1'b1; mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== e_trap) begin errors++; $display("FAIL trap_hold[%0d]: got %b want %b", k, obs, e_trap); end
    end
    @(posedge clk); #1;
    instr = '0; instr_valid = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_mem;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== ZERO_V) begin errors++; $display("FAIL trap_clear: got %b want %b", obs, ZERO_V); end
    @(posedge clk); #1; rst = 1'b0;
    issue(32'h0020A023);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL sw_in_mem: mem_req=%b want 1", mem_req); end
    #2; rst = 1'b1;
    #1;
    checks++;
    if (obs !== ZERO_V) begin errors++; $display("FAIL rst_mid_mem: got %b want %b", obs, ZERO_V); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== ZERO_V) begin errors++; $display("FAIL rst_boot: got %b want %b", obs, ZERO_V); end
    @(negedge clk);
    checks++;
    if (obs !== FETCH_V) begin errors++; $display("FAIL rst_fetch: got %b want %b", obs, FETCH_V); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wb_class();
    test_load();
    test_store();
    test_branch();
    test_stray_acks();
    test_trap();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
